sram_boot_loader: RTL and testbench

//  Upstream boot stage for the main SRAM: receives a byte-serial boot image, packs it

---
 rtl/sram_boot_loader.sv | 142 ++++++++++++++
 tb/tb_sram_boot_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_boot_loader.sv
// Byte-serial boot loader: packs a LEN-prefixed little-endian image into 32-bit SRAM writes
// and holds the CPU in reset until the image is written. Optional trailing XOR checksum: SRAM_BOOT_CHKSUM_EN.
module sram_boot_loader #(
  parameter int SRAM_ADDR_W = 14,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [7:0]             s_data,
  output logic                   s_ready,
  output logic                   i_valid,
  output logic [SRAM_ADDR_W-3:0] i_addr,
  output logic [DATA_W-1:0]      i_wdata,
  output logic [DATA_W/8-1:0]    i_wstrb,
  input  logic                   i_ready,
  output logic                   cpu_rst,
  output logic                   boot_done,
  output logic                   boot_err
);
  localparam int AW = SRAM_ADDR_W - 2;
  localparam int CW = SRAM_ADDR_W - 1;
  localparam logic [31:0] DEPTH = 32'd1 << AW;
`ifdef SRAM_BOOT_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, HDR, DATA, WR, CHK, DONE, ERR} state_t;

  // Stream handshake: a byte moves on a posedge where s_valid && s_ready; the source holds
  // s_valid/s_data until then. SRAM handshake: one i_valid pulse per word, i_ready arrives later.
  state_t            state;
  logic [DATA_W-1:0] word_q;
  logic [1:0]        byte_cnt;
  logic [CW-1:0]     remaining;
  logic [7:0]        xsum_q;
  logic              accept;
  logic [DATA_W-1:0] next_word;

  assign accept    = s_valid & s_ready;
  assign next_word = {s_data, word_q[DATA_W-1:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_q    <= '0;
      byte_cnt  <= '0;
      remaining <= '0;
      xsum_q    <= '0;
      s_ready   <= 1'b0;
      i_valid   <= 1'b0;
      i_addr    <= '0;
      i_wdata   <= '0;
      i_wstrb   <= '0;
      cpu_rst   <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      if (accept) begin
        word_q   <= next_word;
        byte_cnt <= byte_cnt + 2'd1;
        if (state != CHK) xsum_q <= xsum_q ^ s_data;
      end
      case (state)
        IDLE: begin
          state   <= HDR;
          s_ready <= 1'b1;
        end
        HDR: begin
          if (accept && byte_cnt == 2'd3) begin
            if (next_word > DEPTH) begin
              state    <= ERR;
              s_ready  <= 1'b0;
              boot_err <= 1'b1;
            end else if (next_word == '0) begin
              if (CHK_EN) begin
                state <= CHK;
              end else begin
                state     <= DONE;
                s_ready   <= 1'b0;
                cpu_rst   <= 1'b0;
                boot_done <= 1'b1;
              end
            end else begin
              state     <= DATA;
              remaining <= next_word[CW-1:0];
            end
          end
        end
        DATA: begin
          if (accept && byte_cnt == 2'd3) begin
            state   <= WR;
            s_ready <= 1'b0;
            i_valid <= 1'b1;
            i_wdata <= next_word;
            i_wstrb <= '1;
          end
        end
        WR: begin
          i_valid <= 1'b0;
          i_wstrb <= '0;
          // The reply cannot belong to this request while the pulse is still high.
          if (i_ready && !i_valid) begin
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              if (CHK_EN) begin
                state   <= CHK;
                s_ready <= 1'b1;
              end else begin
                state     <= DONE;
                cpu_rst   <= 1'b0;
                boot_done <= 1'b1;
              end
            end else begin
              i_addr  <= i_addr + AW'(1);
              state   <= DATA;
              s_ready <= 1'b1;
            end
          end
        end
        CHK: begin
          if (accept) begin
            s_ready <= 1'b0;
            if (s_data == xsum_q) begin
              state     <= DONE;
              cpu_rst   <= 1'b0;
              boot_done <= 1'b1;
            end else begin
              state    <= ERR;
              boot_err <= 1'b1;
            end
          end
        end
        DONE: state <= DONE;
        ERR:  state <= ERR;
        default: state <= ERR;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_boot_loader.sv
// Self-checking bench for sram_boot_loader: table of images plus random images, SRAM write
// scoreboard fed by an image-level model. Honours SRAM_BOOT_CHKSUM_EN when defined.
module tb_sram_boot_loader;
  localparam int SRAM_ADDR_W = 8;
  localparam int AW = SRAM_ADDR_W - 2;
  localparam int DEPTH = 1 << AW;
  localparam int W = AW + 32;
`ifdef SRAM_BOOT_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready;
  logic          i_valid;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_wdata;
  logic [3:0]    i_wstrb;
  logic          i_ready = 1'b0;
  logic          cpu_rst, boot_done, boot_err;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  int n_writes = 0;
  bit prev_valid = 0;
  bit pending = 0;
  int rdy_cnt = 0;

  typedef struct {
    logic [31:0] len;
    int          pattern;
    int          gap_max;
    bit          bad_chk;
    bit          exp_done;
    bit          exp_err;
  } vec_t;
  vec_t vecs[7];

  sram_boot_loader #(.SRAM_ADDR_W(SRAM_ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .i_valid(i_valid), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .i_ready(i_ready), .cpu_rst(cpu_rst), .boot_done(boot_done), .boot_err(boot_err)
  );

  // Clock and watchdog
  initial forever #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SRAM model and write scoreboard; replies 1-2 cycles after each pulse.
  always @(negedge clk) begin
    if (rst) begin
      pending = 0; prev_valid = 0; rdy_cnt = 0; i_ready = 1'b0;
    end else begin
      if (i_ready) pending = 0;
      if (pending) check("s_ready_in_wr", s_ready, 0);
      if (i_valid) begin
        check("i_valid_single_cycle", prev_valid, 0);
        check("i_valid_before_ready", pending, 0);
        check("i_wstrb_active", i_wstrb, 4'hF);
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("write_addr_data", {i_addr, i_wdata}, exp_w);
        end
        n_writes++;
      end else begin
        check("i_wstrb_idle", i_wstrb, 0);
      end
      i_ready = 1'b0;
      if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) i_ready = 1'b1;
      end
      if (i_valid) begin
        pending = 1;
        rdy_cnt = $urandom_range(1, 2);
      end
      prev_valid = i_valid;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_i_valid"}, i_valid, 0);
    check({tag, "_i_addr"}, i_addr, 0);
    check({tag, "_i_wdata"}, i_wdata, 0);
    check({tag, "_i_wstrb"}, i_wstrb, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_boot_done"}, boot_done, 0);
    check({tag, "_boot_err"}, boot_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    exp_q.delete();
    n_writes = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Driver: offer one byte after a random idle gap, return once it has been taken.
  task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
    int budget = 200;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (budget > 0);
    check("byte_accept_timeout", ok, 1);
    if (ok) @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Builds the image from the format rules, loads expected writes, sends it, checks the end state.
  task automatic run_image(input logic [31:0] len, input int pattern, input int gap_max,
                           input bit bad_chk, input int stop_after,
                           input bit exp_done, input bit exp_err);
    logic [7:0]  img[$];
    logic [7:0]  b, x;
    logic [31:0] wd;
    bit ok;
    int cyc, exp_writes;
    for (int k = 0; k < 4; k++) img.push_back(len[8*k +: 8]);
    exp_writes = (len <= DEPTH) ? int'(len) : 0;
    for (int w = 0; w < exp_writes; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (pattern == 0)      b = 8'(8'h11 * (4*w + k + 1));
        else if (pattern == 2) b = 8'(4*w + k + 1);
        else                   b = 8'($urandom);
        img.push_back(b);
        wd[8*k +: 8] = b;
      end
      exp_q.push_back({AW'(w), wd});
    end
    if (CHK_EN && len <= DEPTH) begin
      x = 8'h00;
      foreach (img[i]) x ^= img[i];
      img.push_back(bad_chk ? (x ^ 8'h05) : x);
    end
    check("start_cpu_rst", cpu_rst, 1);
    check("start_boot_done", boot_done, 0);
    foreach (img[i]) begin
      if (stop_after >= 0 && i == stop_after) return;
      send_byte(img[i], gap_max, ok);
      if (!ok) return;
    end
    cyc = 0;
    while (!boot_done && !boot_err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("finish_timeout", cyc < 100, 1);
    if (!CHK_EN && len == 0) check("len0_latency", cyc <= 2, 1);
    check("boot_done", boot_done, exp_done);
    check("boot_err", boot_err, exp_err);
    check("cpu_rst", cpu_rst, !exp_done);
    check("writes_count", n_writes, exp_writes);
    check("writes_left", exp_q.size(), 0);
    // Bytes past the image must never be taken.
    s_valid = 1'b1;
    s_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      check("s_ready_after_end", s_ready, 0);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] len;
    bit bad, ok_img;
    vecs[0] = '{len: 32'd2,             pattern: 0, gap_max: 0, bad_chk: 0, exp_done: 1, exp_err: 0};
    vecs[1] = '{len: 32'd0,             pattern: 1, gap_max: 0, bad_chk: 0, exp_done: 1, exp_err: 0};
    vecs[2] = '{len: 32'(DEPTH + 1),    pattern: 1, gap_max: 2, bad_chk: 0, exp_done: 0, exp_err: 1};
    vecs[3] = '{len: 32'(DEPTH),        pattern: 1, gap_max: 3, bad_chk: 0, exp_done: 1, exp_err: 0};
    vecs[4] = '{len: 32'h0001_0001,     pattern: 1, gap_max: 1, bad_chk: 0, exp_done: 0, exp_err: 1};
    vecs[5] = '{len: 32'd1,             pattern: 2, gap_max: 1, bad_chk: 0, exp_done: 1, exp_err: 0};
`ifdef SRAM_BOOT_CHKSUM_EN
    vecs[6] = '{len: 32'd1,             pattern: 2, gap_max: 0, bad_chk: 1, exp_done: 0, exp_err: 1};
`else
    vecs[6] = '{len: 32'(DEPTH - 1),    pattern: 1, gap_max: 2, bad_chk: 0, exp_done: 1, exp_err: 0};
`endif

    for (int i = 0; i < 7; i++) begin
      do_reset();
      run_image(vecs[i].len, vecs[i].pattern, vecs[i].gap_max, vecs[i].bad_chk, -1,
                vecs[i].exp_done, vecs[i].exp_err);
    end

    // Reset in the middle of an image, then a fresh LEN=1 image.
    do_reset();
    run_image(32'd3, 1, 1, 0, 9, 0, 0);
    #2 rst = 1'b1;
    #1 check_reset_vals("mid_image_rst");
    exp_q.delete();
    n_writes = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_image(32'd1, 1, 0, 0, -1, 1, 0);

    // Random images against the model: done iff LEN fits and checksum is right.
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 4) == 0) len = 32'(DEPTH + $urandom_range(1, 1000));
      else len = 32'($urandom_range(0, DEPTH));
      bad = CHK_EN && ($urandom_range(0, 3) == 0);
      ok_img = (len <= DEPTH) && !bad;
      do_reset();
      run_image(len, 1, $urandom_range(0, 3), bad, -1, ok_img, !ok_img);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
